// File: rtl/pc_reg_pkg.sv
// Project-wide program-counter constants shared by the IF stage, instruction memory,
// PC adder and IF/ID register.
package pc_reg_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_VALUE = 32'h0000_0000;

endpackage : pc_reg_pkg

// File: rtl/pc_reg_if.sv
// Bundle of PC control and data signals between the IF-stage control logic and the PC register.
interface pc_reg_if #(
  parameter int unsigned PC_WIDTH = pc_reg_pkg::PC_WIDTH
);

  logic                i_enable;
  logic                PCWrite;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] pc_out;

  // Drives the next PC and the write qualifiers, and observes the current PC.
  modport master (
    output i_enable,
    output PCWrite,
    output pc_in,
    input  pc_out
  );

  // The PC register itself.
  modport slave (
    input  i_enable,
    input  PCWrite,
    input  pc_in,
    output pc_out
  );

endinterface : pc_reg_if

// File: rtl/pc_reg.sv
// IF-stage program counter: loads the next PC when the pipeline is enabled and the
// hazard unit allows a write, otherwise holds; async active-low reset to RESET_VALUE.
module pc_reg #(
  parameter int unsigned             PC_WIDTH    = pc_reg_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]     RESET_VALUE = PC_WIDTH'(pc_reg_pkg::RESET_VALUE)
) (
  input  logic     i_clk,
  input  logic     i_reset,
  pc_reg_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic                load_c;

  // Both the global step enable and the hazard permission are needed to advance.
  assign load_c = bus.i_enable & bus.PCWrite;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q <= RESET_VALUE;
    end else if (load_c) begin
      pc_q <= bus.pc_in;
    end
  end

  assign bus.pc_out = pc_q;

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: reference model pushes expected PCs to a scoreboard queue,
// popped and compared one step after each clock edge.
module tb_pc_reg;

  localparam int unsigned W = pc_reg_pkg::PC_WIDTH;
  localparam logic [W-1:0] RST_VAL = pc_reg_pkg::RESET_VALUE;

  logic i_clk;
  logic i_reset;

  pc_reg_if #(.PC_WIDTH(W)) bus ();

  pc_reg #(.PC_WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned    tests_run = 0;
  int unsigned    tests_failed = 0;
  logic [W-1:0]   model_pc;
  logic [W-1:0]   sb[$];

  task automatic check(input string tag, input logic [W-1:0] exp);
    tests_run++;
    assert (bus.pc_out === exp) else begin
      tests_failed++;
      $error("FAIL %s: pc_out=%h expected=%h", tag, bus.pc_out, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [W-1:0] exp;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard empty, pc_out=%h expected=<entry>", tag, bus.pc_out);
    end else begin
      exp = sb.pop_front();
      check(tag, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic rst, input logic en, input logic pw,
                      input logic [W-1:0] d, input string tag);
    @(negedge i_clk);
    i_reset      = rst;
    bus.i_enable = en;
    bus.PCWrite  = pw;
    bus.pc_in    = d;
    if (!rst)          model_pc = RST_VAL;
    else if (en && pw) model_pc = d;
    sb.push_back(model_pc);
    @(posedge i_clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    logic [W-1:0] rnd;
    logic         re, rp;

    // Reset asserted from time zero, before any clock edge.
    i_reset      = 1'b0;
    bus.i_enable = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.pc_in    = W'(100);
    model_pc     = RST_VAL;
    #1;
    check("reset_async_initial", RST_VAL);

    step(1'b0, 1'b1, 1'b1, W'(100), "reset_holds_over_edge");
    step(1'b1, 1'b0, 1'b0, W'(100), "reset_release");
    step(1'b1, 1'b0, 1'b1, W'(200), "global_freeze");
    step(1'b1, 1'b1, 1'b0, W'(300), "hazard_stall");
    step(1'b1, 1'b1, 1'b1, W'(400), "load_400");
    step(1'b1, 1'b0, 1'b1, W'(500), "hold_after_load");

    // Asynchronous reset between edges with a qualified load pending.
    @(negedge i_clk);
    bus.i_enable = 1'b1;
    bus.PCWrite  = 1'b1;
    bus.pc_in    = W'(32'h0000_0123);
    #1;
    check("pre_async_reset", W'(400));
    i_reset  = 1'b0;
    model_pc = RST_VAL;
    #1;
    check("async_reset_mid_cycle", RST_VAL);
    @(posedge i_clk);
    #1;
    check("async_reset_beats_load", RST_VAL);

    // Release with loads disabled keeps the reset value; the held 400 is gone.
    step(1'b1, 1'b0, 1'b0, W'(32'h0000_0777), "post_reset_no_load");
    step(1'b1, 1'b1, 1'b0, W'(32'h0000_0888), "post_reset_stall");

    // First edge with reset released may load directly.
    step(1'b0, 1'b0, 1'b0, W'(0), "reset_again");
    step(1'b1, 1'b1, 1'b1, W'(32'h0000_0040), "load_on_release_edge");

    // Back-to-back loads including the top word-aligned address, no masking.
    step(1'b1, 1'b1, 1'b1, W'(32'h0000_0004), "b2b_4");
    step(1'b1, 1'b1, 1'b1, W'(32'h0000_0008), "b2b_8");
    step(1'b1, 1'b1, 1'b1, W'(32'hFFFF_FFFC), "b2b_top");
    step(1'b1, 1'b1, 1'b1, W'(32'hFFFF_FFFF), "b2b_all_ones_unaligned");
    step(1'b1, 1'b0, 1'b0, W'(32'h1234_5678), "hold_all_ones");

    // Randomised enables and data against the reference model.
    for (int i = 0; i < 24; i++) begin
      rnd = W'($urandom());
      re  = 1'($urandom_range(0, 1));
      rp  = 1'($urandom_range(0, 1));
      step(1'b1, re, rp, rnd, $sformatf("rand_%0d", i));
    end

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc_reg
